// File: rtl/wb_led_pwm_if.sv
// Wishbone classic slave bus bundle for the LED PWM controller.
// Master drives address/data/select/we/cyc/stb; slave returns read data and ack.
// Ports: adr, wdat, sel, we, cyc, stb (master->slave); rdat, ack (slave->master).
interface wb_led_pwm_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdat;
  logic        ack;

  modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack);
  modport slave  (input adr, wdat, sel, we, cyc, stb, output rdat, ack);
endinterface

// File: rtl/wb_led_pwm.sv
// Wishbone LED controller: per-channel direct or shared-timebase PWM drive with a global blink gate.
// Latency: bus ack one clock after the access; o_leds one clock after internal state.
// Backpressure: none; every access acks on the next clock, so a held strobe acks every other cycle.
// Ports: i_clk, i_reset_n (async active-low), o_leds (registered LED drive), bus (Wishbone slave modport).
module wb_led_pwm #(
  parameter int NUM_LEDS      = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  output logic [NUM_LEDS-1:0] o_leds,
  wb_led_pwm_if.slave         bus
);

  // Configuration registers
  logic [1:0]               ctrl_q;
  logic [NUM_LEDS-1:0]      direct_q;
  logic [NUM_LEDS-1:0]      mode_q;
  logic [PRESCALE_BITS-1:0] presc_q;
  logic [15:0]              blink_q;
  logic [PWM_BITS-1:0]      duty_q   [NUM_LEDS];
  logic [PWM_BITS-1:0]      shadow_q [NUM_LEDS];

  // Timebase and output state
  logic [PRESCALE_BITS-1:0] presc_cnt_q;
  logic [PWM_BITS-1:0]      pwm_cnt_q;
  logic [15:0]              blink_cnt_q;
  logic                     phase_q;
  logic [NUM_LEDS-1:0]      leds_q, leds_d;
  logic                     ack_q;
  logic [31:0]              rdat_q, rdat_d;

  logic [5:0]  widx;
  logic        access, wr_en, tick, boundary;
  logic [31:0] rd_word, wr_word;
  logic        unused_bits;

  assign widx   = bus.adr[7:2];
  assign access = bus.cyc & bus.stb & ~ack_q;
  assign wr_en  = access & bus.we;
  assign unused_bits = ^{bus.adr[31:8], bus.adr[1:0], wr_word};

  // >= rather than == so that lowering PRESC below the running count wraps at once.
  assign tick     = (presc_cnt_q >= presc_q);
  assign boundary = tick & (&pwm_cnt_q);

  // Read mux; fields narrower than 32 bits zero-extend.
  always_comb begin
    rd_word = '0;
    case (widx)
      6'd0: rd_word = 32'(ctrl_q);
      6'd1: rd_word = 32'(direct_q);
      6'd2: rd_word = 32'(mode_q);
      6'd3: rd_word = 32'(presc_q);
      6'd4: rd_word = 32'(blink_q);
      6'd5: rd_word = (32'(pwm_cnt_q) << 16) | {31'b0, phase_q};
      default: begin
        for (int n = 0; n < NUM_LEDS; n++) begin
          if (widx == 6'(16 + n)) rd_word = 32'(duty_q[n]);
        end
      end
    endcase
  end

  // Byte-lane merge of write data over the current register contents.
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.sel[b]) wr_word[8*b +: 8] = bus.wdat[8*b +: 8];
    end
  end

  assign rdat_d = access ? rd_word : '0;

  always_comb begin
    leds_d = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      leds_d[n] = ctrl_q[0] & phase_q &
                  (mode_q[n] ? (pwm_cnt_q < shadow_q[n]) : direct_q[n]);
    end
  end

  // Bus-side register file and handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_q   <= '0;
      direct_q <= '0;
      mode_q   <= '0;
      presc_q  <= '0;
      blink_q  <= '0;
      for (int n = 0; n < NUM_LEDS; n++) duty_q[n] <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
    end else begin
      ack_q  <= access;
      rdat_q <= rdat_d;
      if (wr_en) begin
        case (widx)
          6'd0: ctrl_q   <= wr_word[1:0];
          6'd1: direct_q <= wr_word[NUM_LEDS-1:0];
          6'd2: mode_q   <= wr_word[NUM_LEDS-1:0];
          6'd3: presc_q  <= wr_word[PRESCALE_BITS-1:0];
          6'd4: blink_q  <= wr_word[15:0];
          default: begin
            for (int n = 0; n < NUM_LEDS; n++) begin
              if (widx == 6'(16 + n)) duty_q[n] <= wr_word[PWM_BITS-1:0];
            end
          end
        endcase
      end
    end
  end

  // Timebase, duty shadows, blink and output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      for (int n = 0; n < NUM_LEDS; n++) shadow_q[n] <= '0;
      leds_q      <= '0;
    end else begin
      presc_cnt_q <= tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
      // duty_q is sampled before this edge's bus write, so a coincident
      // DUTY write waits for the following boundary.
      if (boundary) begin
        for (int n = 0; n < NUM_LEDS; n++) shadow_q[n] <= duty_q[n];
      end
      if (!ctrl_q[1]) begin
        phase_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (boundary) begin
        if (blink_cnt_q == blink_q) begin
          phase_q     <= ~phase_q;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
      leds_q <= leds_d;
    end
  end

  assign o_leds   = leds_q;
  assign bus.ack  = ack_q;
  assign bus.rdat = rdat_q;

endmodule

// File: tb/tb_wb_led_pwm.sv
// Directed bench for wb_led_pwm with default parameters (8 LEDs, 8-bit PWM, 16-bit prescaler).
// Latency: transfers wait at most 8 clocks for ack; all outputs sampled 1 time unit after posedge.
// Backpressure: none; the bench issues one transfer at a time.
module tb_wb_led_pwm;
  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [7:0] o_leds;
  int         errors = 0;
  int         checks = 0;

  wb_led_pwm_if bus ();

  wb_led_pwm #(.NUM_LEDS(8), .PWM_BITS(8), .PRESCALE_BITS(16)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_leds    (o_leds),
    .bus       (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.wdat = '0; bus.sel = '0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    logic ok;
    ok = 1'b0;
    rd = '0;
    @(posedge i_clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
    bus.adr = a; bus.wdat = d; bus.sel = s;
    for (int k = 0; k < 8; k++) begin
      @(posedge i_clk); #1;
      if (bus.ack) begin
        ok = 1'b1;
        rd = bus.rdat;
        break;
      end
    end
    bus_idle();
    if (!ok) check("ack_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, 4'hF, r);
    check(tag, r, exp);
  endtask

  initial begin
    int c0a, c1a, c2a, c3a, c0b, c1b, c1c, acks, lo, hi;
    logic found;
    logic [31:0] dummy;

    // 1. Reset held while the bus is driven randomly
    bus_idle();
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      bus.cyc = 1'($urandom); bus.stb = 1'($urandom); bus.we = 1'($urandom);
      bus.adr = {24'b0, 6'($urandom), 2'b00}; bus.wdat = $urandom; bus.sel = 4'($urandom);
    end
    check("rst_leds", 32'(o_leds), 32'h0);
    check("rst_ack", {31'b0, bus.ack}, 32'h0);
    check("rst_rdat", bus.rdat, 32'h0);
    bus_idle();
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    rd_check("rst_ctrl",   32'h00, 32'h0);
    rd_check("rst_direct", 32'h04, 32'h0);
    rd_check("rst_mode",   32'h08, 32'h0);
    rd_check("rst_presc",  32'h0C, 32'h0);
    rd_check("rst_blink",  32'h10, 32'h0);
    rd_check("rst_duty0",  32'h40, 32'h0);
    rd_check("rst_duty7",  32'h5C, 32'h0);

    // 2. Direct drive
    wr(32'h04, 32'hA5);
    wr(32'h08, 32'h00);
    wr(32'h00, 32'h01);
    repeat (2) @(posedge i_clk);
    #1 check("direct_a5", 32'(o_leds), 32'hA5);
    wr(32'h00, 32'h00);
    repeat (2) @(posedge i_clk);
    #1 check("direct_en0", 32'(o_leds), 32'h00);

    // Field-width truncation and held-strobe ack cadence
    wr(32'h04, 32'hFFFF_FFFF);
    rd_check("direct_trunc", 32'h04, 32'h0000_00FF);
    wr(32'h00, 32'hFFFF_FFFF);
    rd_check("ctrl_trunc", 32'h00, 32'h0000_0003);
    wr(32'h00, 32'h0);
    @(posedge i_clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h00; bus.sel = 4'hF;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk); #1;
      if (bus.ack) acks++;
    end
    bus_idle();
    check("held_stb_acks", 32'(acks), 32'd3);

    // 3/4. PWM duties, mid-period duty change, and DUTY write on a boundary
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFF);
    wr(32'h40, 32'd64);
    wr(32'h44, 32'd0);
    wr(32'h48, 32'd255);
    wr(32'h4C, 32'd0);
    wr(32'h00, 32'h1);
    repeat (300) @(posedge i_clk);
    // LED2 (duty 255) is low for exactly one sample per period; after it the counter is 0.
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge i_clk); #1;
      if (!o_leds[2]) begin found = 1'b1; break; end
    end
    check("pwm_sync", {31'b0, found}, 32'd1);
    c0a = 0; c1a = 0; c2a = 0; c3a = 0; c0b = 0; c1b = 0; c1c = 0;
    for (int i = 1; i <= 768; i++) begin
      @(posedge i_clk); #1;
      if (bus.ack) bus_idle();
      if (i <= 256) begin
        c0a += 32'(o_leds[0]); c1a += 32'(o_leds[1]);
        c2a += 32'(o_leds[2]); c3a += 32'(o_leds[3]);
      end else if (i <= 512) begin
        c0b += 32'(o_leds[0]); c1b += 32'(o_leds[1]);
      end else begin
        c1c += 32'(o_leds[1]);
      end
      if (i == 100) begin
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 32'h40; bus.wdat = 32'd200; bus.sel = 4'hF;
      end
      if (i == 255) begin  // access lands on the period boundary edge
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 32'h44; bus.wdat = 32'd128; bus.sel = 4'hF;
      end
    end
    bus_idle();
    check("pwm_led0_d64",  32'(c0a), 32'd64);
    check("pwm_led1_d0",   32'(c1a), 32'd0);
    check("pwm_led2_d255", 32'(c2a), 32'd255);
    check("pwm_led3_d0",   32'(c3a), 32'd0);
    check("pwm_led0_d200", 32'(c0b), 32'd200);
    check("bnd_led1_old",  32'(c1b), 32'd0);
    check("bnd_led1_new",  32'(c1c), 32'd128);

    // 5. Blink: half-period of 2 PWM periods = 512 clocks
    wr(32'h08, 32'h00);
    wr(32'h04, 32'hFF);
    wr(32'h10, 32'h1);
    wr(32'h00, 32'h3);
    repeat (2) @(posedge i_clk);
    found = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(posedge i_clk); #1;
      if (o_leds == 8'h00) begin found = 1'b1; break; end
    end
    check("blink_sync", {31'b0, found}, 32'd1);
    lo = 1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge i_clk); #1;
      if (o_leds == 8'h00) lo++; else break;
    end
    check("blink_off_run", 32'(lo), 32'd512);
    check("blink_on_val", 32'(o_leds), 32'hFF);
    hi = 1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge i_clk); #1;
      if (o_leds == 8'hFF) hi++; else break;
    end
    check("blink_on_run", 32'(hi), 32'd512);

    // 6. Byte-lane write and unmapped addresses
    wr(32'h0C, 32'h0000_0012);
    xfer(1'b1, 32'h0C, 32'h0000_3400, 4'b0010, dummy);
    rd_check("presc_bytelane", 32'h0C, 32'h0000_3412);
    wr(32'h7C, 32'hFFFF_FFFF);
    rd_check("unmapped_7c", 32'h7C, 32'h0);
    wr(32'h60, 32'hFFFF_FFFF);
    rd_check("unmapped_duty8", 32'h60, 32'h0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd_check("status_ro_ctrl", 32'h00, 32'h3);

    // Reset in the middle of a transfer
    @(posedge i_clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = 32'h04; bus.wdat = 32'h0; bus.sel = 4'hF;
    #2 i_reset_n = 1'b0;
    #1 check("midrst_leds", 32'(o_leds), 32'h0);
    check("midrst_ack0", {31'b0, bus.ack}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 check("midrst_ack1", {31'b0, bus.ack}, 32'h0);
    bus_idle();
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    rd_check("midrst_blink", 32'h10, 32'h0);
    rd_check("midrst_presc", 32'h0C, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
